// File: rtl/mem_request_unit.sv
// mem_request_unit: CPU-side initiator for memory_control.
// Arbitrates instruction fetch against load/store with alternating priority,
// issues stores in a single cycle from IDLE, and runs reads through
// RD_ADDR/RD_WAIT with a bounded wait for read_valid before a bus_error abort.
module mem_request_unit #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [15:0] if_addr,
  output logic        if_resp_valid,
  output logic [15:0] if_resp_data,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic        ls_req_write,
  input  logic [15:0] ls_addr,
  input  logic [15:0] ls_wdata,
  output logic        ls_resp_valid,
  output logic [15:0] ls_resp_data,
  output logic        bus_error,
  output logic [15:0] read_address,
  output logic [15:0] write_address,
  output logic [15:0] write_data,
  output logic        write_enable,
  input  logic [15:0] read_data,
  input  logic        read_valid
);

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_WAIT} state_t;

  state_t        state;
  logic          last_grant;   // 0 = fetch, 1 = load/store
  logic          rd_is_ls;     // owner of the read in flight
  logic [CW-1:0] wait_cnt;
  logic          grant_if;
  logic          grant_ls;
  logic          rd_timeout;

  // Grant selection: only in IDLE, alternating when both clients request
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (!reset && state == IDLE) begin
      if (if_req_valid && ls_req_valid) begin
        if (last_grant) grant_if = 1'b1;
        else            grant_ls = 1'b1;
      end else begin
        grant_if = if_req_valid;
        grant_ls = ls_req_valid;
      end
    end
  end

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;
  assign rd_timeout   = (state == RD_WAIT) && !read_valid &&
                        (wait_cnt == CW'(TIMEOUT - 1));

  // Request sequencing, memory-side drive and client responses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b0;
      rd_is_ls      <= 1'b0;
      wait_cnt      <= '0;
      if_resp_valid <= 1'b0;
      if_resp_data  <= '0;
      ls_resp_valid <= 1'b0;
      ls_resp_data  <= '0;
      bus_error     <= 1'b0;
      read_address  <= '0;
      write_address <= '0;
      write_data    <= '0;
      write_enable  <= 1'b0;
    end else begin
      if_resp_valid <= 1'b0;
      ls_resp_valid <= 1'b0;
      bus_error     <= 1'b0;
      write_enable  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if) begin
            last_grant   <= 1'b0;
            rd_is_ls     <= 1'b0;
            read_address <= if_addr;
            state        <= RD_ADDR;
          end else if (grant_ls) begin
            last_grant <= 1'b1;
            if (ls_req_write) begin
              write_enable  <= 1'b1;
              write_address <= ls_addr;
              write_data    <= ls_wdata;
              ls_resp_valid <= 1'b1;
              ls_resp_data  <= '0;
              bus_error     <= (ls_addr[15:14] != 2'b10);
            end else begin
              rd_is_ls     <= 1'b1;
              read_address <= ls_addr;
              state        <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          wait_cnt <= '0;
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (read_valid || rd_timeout) begin
            if (rd_is_ls) begin
              ls_resp_valid <= 1'b1;
              ls_resp_data  <= read_valid ? read_data : '0;
            end else begin
              if_resp_valid <= 1'b1;
              if_resp_data  <= read_valid ? read_data : '0;
            end
            bus_error <= !read_valid;
            wait_cnt  <= '0;
            state     <= IDLE;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed bench for mem_request_unit with a registered-read memory model:
// ROM contents come from a small lookup, RAM (0x8000 region) is an array.
module tb_mem_request_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [15:0] if_addr = '0;
  logic        if_resp_valid;
  logic [15:0] if_resp_data;
  logic        ls_req_valid = 1'b0;
  logic        ls_req_ready;
  logic        ls_req_write = 1'b0;
  logic [15:0] ls_addr = '0;
  logic [15:0] ls_wdata = '0;
  logic        ls_resp_valid;
  logic [15:0] ls_resp_data;
  logic        bus_error;
  logic [15:0] read_address;
  logic [15:0] write_address;
  logic [15:0] write_data;
  logic        write_enable;
  logic [15:0] read_data = '0;
  logic        read_valid = 1'b0;
  logic        rv_en = 1'b1;

  int checks = 0;
  int errors = 0;
  int n;
  logic exp_if;

  logic [15:0] ram [0:255];

  mem_request_unit #(.TIMEOUT(16), .CW(5)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
    .ls_req_write(ls_req_write), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
    .bus_error(bus_error), .read_address(read_address),
    .write_address(write_address), .write_data(write_data),
    .write_enable(write_enable), .read_data(read_data), .read_valid(read_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    case (a)
      16'h0012: rom_word = 16'hA5C3;
      16'h0000: rom_word = 16'h1111;
      default:  rom_word = 16'h0000;
    endcase
  endfunction

  // Memory model: write on enable into RAM, registered read, delayed qualifier
  always @(posedge clock) begin
    if (write_enable && write_address[15:14] == 2'b10)
      ram[write_address[7:0]] <= write_data;
    if (read_address[15:14] == 2'b10) read_data <= ram[read_address[7:0]];
    else                              read_data <= rom_word(read_address);
    read_valid <= rv_en;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    if_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    #1;
    chk("rst_if_ready", {15'd0, if_req_ready}, 16'd0);
    chk("rst_ls_ready", {15'd0, ls_req_ready}, 16'd0);
    chk("rst_rd_addr", read_address, 16'h0000);
    chk("rst_we", {15'd0, write_enable}, 16'd0);
    chk("rst_resp", {14'd0, if_resp_valid, ls_resp_valid}, 16'd0);
    chk("rst_berr", {15'd0, bus_error}, 16'd0);
    ls_req_valid = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    #1;

    // Fetch 0x0012
    if_addr = 16'h0012;
    chk("f_ready", {15'd0, if_req_ready}, 16'd1);
    tick;                                   // E0
    if_req_valid = 1'b0;
    chk("f_ra1", read_address, 16'h0012);
    chk("f_novalid1", {15'd0, if_resp_valid}, 16'd0);
    tick;
    chk("f_ra2", read_address, 16'h0012);
    chk("f_novalid2", {15'd0, if_resp_valid}, 16'd0);
    tick;
    chk("f_valid", {15'd0, if_resp_valid}, 16'd1);
    chk("f_data", if_resp_data, 16'hA5C3);
    chk("f_berr", {15'd0, bus_error}, 16'd0);
    tick;
    chk("f_pulse_end", {15'd0, if_resp_valid}, 16'd0);

    // Store 0xBEEF to 0x8004, then load it back
    ls_req_valid = 1'b1;
    ls_req_write = 1'b1;
    ls_addr      = 16'h8004;
    ls_wdata     = 16'hBEEF;
    #1;
    chk("st_ready", {15'd0, ls_req_ready}, 16'd1);
    tick;                                   // store E0
    ls_req_write = 1'b0;
    chk("st_we", {15'd0, write_enable}, 16'd1);
    chk("st_waddr", write_address, 16'h8004);
    chk("st_wdata", write_data, 16'hBEEF);
    chk("st_ack", {15'd0, ls_resp_valid}, 16'd1);
    chk("st_ackdata", ls_resp_data, 16'h0000);
    chk("st_berr", {15'd0, bus_error}, 16'd0);
    chk("ld_ready", {15'd0, ls_req_ready}, 16'd1);
    tick;                                   // load E0
    ls_req_valid = 1'b0;
    chk("st_we_fall", {15'd0, write_enable}, 16'd0);
    chk("st_ack_end", {15'd0, ls_resp_valid}, 16'd0);
    tick;
    tick;
    chk("ld_valid", {15'd0, ls_resp_valid}, 16'd1);
    chk("ld_data", ls_resp_data, 16'hBEEF);
    chk("ld_no_if", {15'd0, if_resp_valid}, 16'd0);

    // Continuous contention: last grant was LS, so IF, LS, IF, LS
    if_req_valid = 1'b1;
    if_addr      = 16'h0000;
    ls_req_valid = 1'b1;
    ls_addr      = 16'h8004;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_if = (k % 2 == 0);
      chk("arb_if_ready", {15'd0, if_req_ready}, {15'd0, exp_if});
      chk("arb_ls_ready", {15'd0, ls_req_ready}, {15'd0, !exp_if});
      tick;
      tick;
      tick;
      chk("arb_if_resp", {15'd0, if_resp_valid}, {15'd0, exp_if});
      chk("arb_ls_resp", {15'd0, ls_resp_valid}, {15'd0, !exp_if});
      if (exp_if) chk("arb_if_data", if_resp_data, 16'h1111);
      else        chk("arb_ls_data", ls_resp_data, 16'hBEEF);
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    tick;

    // Load with read_valid held low: timeout abort
    rv_en = 1'b0;
    tick;
    ls_req_valid = 1'b1;
    ls_addr      = 16'h8000;
    #1;
    chk("to_ready", {15'd0, ls_req_ready}, 16'd1);
    tick;                                   // E0
    ls_req_valid = 1'b0;
    n = 0;
    while (n < 40 && !ls_resp_valid) begin
      tick;
      n++;
    end
    chk("to_latency", 16'(n), 16'd17);
    chk("to_valid", {15'd0, ls_resp_valid}, 16'd1);
    chk("to_data", ls_resp_data, 16'h0000);
    chk("to_berr", {15'd0, bus_error}, 16'd1);
    rv_en = 1'b1;
    if_req_valid = 1'b1;
    if_addr      = 16'h0012;
    #1;
    chk("to_next_ready", {15'd0, if_req_ready}, 16'd1);
    tick;
    if_req_valid = 1'b0;
    tick;
    tick;
    chk("to_next_valid", {15'd0, if_resp_valid}, 16'd1);
    chk("to_next_data", if_resp_data, 16'hA5C3);
    chk("to_next_berr", {15'd0, bus_error}, 16'd0);
    tick;

    // Store into ROM region: forwarded, flagged
    ls_req_valid = 1'b1;
    ls_req_write = 1'b1;
    ls_addr      = 16'h1234;
    ls_wdata     = 16'h5555;
    #1;
    tick;
    ls_req_valid = 1'b0;
    ls_req_write = 1'b0;
    chk("rom_we", {15'd0, write_enable}, 16'd1);
    chk("rom_waddr", write_address, 16'h1234);
    chk("rom_ack", {15'd0, ls_resp_valid}, 16'd1);
    chk("rom_berr", {15'd0, bus_error}, 16'd1);
    tick;
    chk("rom_berr_end", {15'd0, bus_error}, 16'd0);

    // Reset while in RD_WAIT
    rv_en = 1'b0;
    tick;
    if_req_valid = 1'b1;
    if_addr      = 16'h0012;
    #1;
    tick;                                   // E0
    if_req_valid = 1'b0;
    tick;
    tick;                                   // in RD_WAIT
    #2;
    reset = 1'b1;
    if_req_valid = 1'b1;
    #1;
    chk("mr_ra", read_address, 16'h0000);
    chk("mr_wa", write_address, 16'h0000);
    chk("mr_we", {15'd0, write_enable}, 16'd0);
    chk("mr_resp", {14'd0, if_resp_valid, ls_resp_valid}, 16'd0);
    chk("mr_ready", {15'd0, if_req_ready}, 16'd0);
    rv_en = 1'b1;
    tick;
    tick;
    chk("mr_no_resp", {15'd0, if_resp_valid}, 16'd0);
    reset = 1'b0;
    #1;
    chk("mr_idle_ready", {15'd0, if_req_ready}, 16'd1);
    tick;
    if_req_valid = 1'b0;
    chk("mr_ra_new", read_address, 16'h0012);
    tick;
    tick;
    chk("mr_valid", {15'd0, if_resp_valid}, 16'd1);
    chk("mr_data", if_resp_data, 16'hA5C3);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
